func_sweep_ctrl: RTL and testbench
==================================

# func_sweep_ctrl

Sequencer that exhaustively sweeps every input combination of an N-input combinational Boolean function under test. Each vector is driven to two implementations at once: the original expression and a candidate simplification. The block compares their outputs, counts mismatches and records the first failing vector. It sits between a start/done control interface and a pair of combinational function units, and replaces hand-written bench loops with synthesizable, cycle-exact checking.

## Interface
- N_IN, 3, input width of the function under test; sweep covers 2^N_IN vectors (1..8)
- SETTLE, 1, wait cycles after each new vector before outputs are compared (>=1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a sweep; sampled only in IDLE
- ref_in  input  1  output of the original (reference) function
- alt_in  input  1  output of the candidate function
- vec_out  output  N_IN  current input vector, fed to both functions; bit 0 = x, bit 1 = y, bit 2 = z
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse when the sweep ends
- pass  output  1  level; 1 if the last sweep had zero mismatches; held until the next start
- mismatch_cnt  output  N_IN+1  number of vectors where ref_in != alt_in
- fail_valid  output  1  first_fail holds a captured vector
- first_fail  output  N_IN  lowest-numbered vector that mismatched

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1:
  - Clear vec_out, mismatch_cnt, fail_valid, first_fail and pass.
  - Load settle counter with SETTLE−1 and go to SETTLE.
- SETTLE: decrement the counter; at 0 go to CHECK.
- CHECK: compare ref_in against alt_in for vec_out.
  - On mismatch, increment mismatch_cnt.
  - On mismatch with fail_valid=0, capture first_fail=vec_out and set fail_valid.
  - If vec_out == all-ones, go to DONE.
  - Otherwise increment vec_out, reload the settle counter and go to SETTLE.
- DONE:
  - Assert done for one cycle.
  - pass = (mismatch_cnt==0), taking into account the final CHECK's result.
  - Return to IDLE.
- busy=1 in SETTLE, CHECK and DONE.
- start is ignored outside IDLE.
- vec_out never wraps during a sweep. It holds its last value (all-ones, or the failing vector with the config option) in IDLE.
- mismatch_cnt width N_IN+1 holds up to 2^N_IN, so it never saturates or overflows.
- Asynchronous reset, including mid-sweep:
  - Immediately returns to IDLE.
  - All outputs 0: vec_out=0, busy=0, done=0, pass=0, mismatch_cnt=0, fail_valid=0, first_fail=0.
  - No done pulse is produced for the aborted sweep.

## Timing
- All outputs are registered.
- start sampled at edge k → busy=1 and vec_out=0 visible after edge k.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles of settling plus 1 CHECK cycle.
- ref_in and alt_in are sampled at the CHECK edge.
- done is high in the cycle after edge k + 2^N_IN·(SETTLE+1). Defaults: 16 cycles of sweep, done in the 17th cycle.
- busy falls on the edge ending DONE.
- start may be asserted in the cycle after done; the next sweep begins in that cycle's edge.

## Configuration
- FUNC_SWEEP_STOP_ON_FAIL_EN defined:
  - The first mismatching CHECK goes directly to DONE.
  - mismatch_cnt ends at 1, first_fail = vec_out = the failing vector, pass=0.
  - Sweep length = (first_fail+1)·(SETTLE+1) cycles.
- Undefined: every vector is always swept and the full mismatch count is reported.

## Structure
- Package func_sweep_pkg:
  - State enum sweep_state_t (IDLE, SETTLE, CHECK, DONE).
  - Localparam helper for the vector count 2^N_IN.
- One natural sub-module, sweep_settle_timer: loadable down-counter of width $clog2(SETTLE+1) with a zero flag.
- Top level contains the FSM, vector counter, compare and capture logic.

## Test plan
- Candidate equal to the reference, e.g. (x+y)(x̄+z)(y+z) versus (x+y)(x̄+z), defaults → done at cycle 17, pass=1, mismatch_cnt=0, fail_valid=0, vec_out=3'b111.
- alt_in = ref_in XOR (vec_out==5) → mismatch_cnt=1, first_fail=3'b101, fail_valid=1, pass=0.
- alt_in = ~ref_in → mismatch_cnt=8, first_fail=3'b000, pass=0. With FUNC_SWEEP_STOP_ON_FAIL_EN → done at cycle 3, mismatch_cnt=1.
- start pulsed again at cycle 5 of a sweep → ignored; done still at cycle 17 with the same results.
- rst_n low at cycle 9 mid-sweep → all outputs 0 immediately; no done. A new start after release completes normally.
- SETTLE=3, N_IN=2 → done at cycle 17 (4·4+1); vec_out holds each value for 4 cycles.

Source files
------------

// File: rtl/func_sweep_pkg.sv
// Shared types and helpers for the exhaustive Boolean-function sweep controller.
package func_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  // Number of input vectors covered by a sweep of an n_in-input function.
  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that holds each vector stable for a fixed number of cycles.
module sweep_settle_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; the counter parks at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/func_sweep_ctrl.sv
// Sweeps every input vector of an N_IN-input function, compares reference and candidate outputs.
// Optional macro FUNC_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module func_sweep_ctrl
  import func_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            ref_in,
  input  logic            alt_in,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail
);

  localparam int              CNT_W       = $clog2(SETTLE + 1);
  localparam int              MC_W        = N_IN + 1;
  localparam int              N_VEC       = vec_count(N_IN);
  localparam logic [N_IN-1:0] VEC_LAST    = N_IN'(N_VEC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  sweep_state_t    state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [MC_W-1:0] mcnt_q, mcnt_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            fv_q, fv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic            tmr_load;
  logic            tmr_dec;
  logic            tmr_zero;
  logic            mismatch;
  logic            stop_now;
  logic [MC_W-1:0] mcnt_next;

  sweep_settle_timer #(
    .CNT_W (CNT_W)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (SETTLE_LOAD),
    .zero     (tmr_zero)
  );

  assign mismatch  = ref_in ^ alt_in;
  assign mcnt_next = mismatch ? (mcnt_q + MC_W'(1)) : mcnt_q;

`ifdef FUNC_SWEEP_STOP_ON_FAIL_EN
  assign stop_now = (vec_q == VEC_LAST) || mismatch;
`else
  assign stop_now = (vec_q == VEC_LAST);
`endif

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    mcnt_d   = mcnt_q;
    ff_d     = ff_q;
    fv_d     = fv_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d    = '0;
          mcnt_d   = '0;
          ff_d     = '0;
          fv_d     = 1'b0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_CHECK;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_CHECK: begin
        mcnt_d = mcnt_next;
        if (mismatch && !fv_q) begin
          ff_d = vec_q;
          fv_d = 1'b1;
        end
        // pass is resolved here so it already reflects this final comparison when done rises
        if (stop_now) begin
          done_d  = 1'b1;
          pass_d  = (mcnt_next == '0);
          state_d = ST_DONE;
        end else begin
          vec_d    = vec_q + N_IN'(1);
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      mcnt_q  <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mcnt_q  <= mcnt_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_out      = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mcnt_q;
  assign fail_valid   = fv_q;
  assign first_fail   = ff_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Scoreboard bench for func_sweep_ctrl: truth-table driven function pair, sweep-level reference model.
module tb_func_sweep_ctrl;

  localparam int N_IN   = 3;
  localparam int SETTLE = 1;
  localparam int NV     = 1 << N_IN;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            ref_in;
  logic            alt_in;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   mismatch_cnt;
  logic            fail_valid;
  logic [N_IN-1:0] first_fail;

  logic [NV-1:0] ref_tt;
  logic [NV-1:0] alt_tt;

  int n_checks;
  int n_pass;
  int cyc;

  typedef struct {
    int start_cyc;
    int len;
    int cnt;
    int ff;
    int fv;
    int pass;
    int last;
  } exp_t;

  exp_t sb_q[$];

  func_sweep_ctrl #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ref_in       (ref_in),
    .alt_in       (alt_in),
    .vec_out      (vec_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .mismatch_cnt (mismatch_cnt),
    .fail_valid   (fail_valid),
    .first_fail   (first_fail)
  );

  // The two "function units" are truth tables looked up by the current vector.
  assign ref_in = ref_tt[vec_out];
  assign alt_in = alt_tt[vec_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: walk the truth tables vector by vector.
  function automatic exp_t model(input logic [NV-1:0] rt, input logic [NV-1:0] at, input int sc);
    exp_t e;
    e.start_cyc = sc;
    e.cnt  = 0;
    e.ff   = 0;
    e.fv   = 0;
    e.last = NV - 1;
    for (int v = 0; v < NV; v++) begin
      if (rt[v] != at[v]) begin
        e.cnt = e.cnt + 1;
        if (e.fv == 0) begin
          e.fv = 1;
          e.ff = v;
        end
`ifdef FUNC_SWEEP_STOP_ON_FAIL_EN
        e.last = v;
        break;
`endif
      end
    end
    e.pass = (e.cnt == 0) ? 1 : 0;
    e.len  = (e.last + 1) * (SETTLE + 1);
    return e;
  endfunction

  // Monitor: trace vec_out while busy, check done timing and results at the done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        if (sb_q.size() == 0) begin
          chk("busy_without_sweep", busy, 0);
        end else begin
          int t;
          int ev;
          t  = cyc - sb_q[0].start_cyc;
          ev = t / (SETTLE + 1);
          if (ev > sb_q[0].last) ev = sb_q[0].last;
          chk("vec_trace", vec_out, ev);
          chk("done_timing", done, (t == sb_q[0].len) ? 1 : 0);
          if (done) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("mismatch_cnt", mismatch_cnt, e.cnt);
            chk("fail_valid", fail_valid, e.fv);
            chk("first_fail", first_fail, e.ff);
            chk("pass", pass, e.pass);
          end
        end
      end else if (done) begin
        chk("spurious_done", done, 0);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_vec"}, vec_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_mcnt"}, mismatch_cnt, 0);
    chk({tag, "_fv"}, fail_valid, 0);
    chk({tag, "_ff"}, first_fail, 0);
  endtask

  // One sweep; glitch_t re-pulses start mid-sweep, abort_t resets mid-sweep (-1 = unused).
  task automatic run_sweep(input logic [NV-1:0] rt, input logic [NV-1:0] at,
                           input int glitch_t, input int abort_t);
    int sc;
    int t;
    bit seen;
    @(negedge clk);
    ref_tt = rt;
    alt_tt = at;
    sc = cyc + 1;
    sb_q.push_back(model(rt, at, sc));
    start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      t = cyc - sc;
      start = (t == glitch_t) ? 1'b1 : 1'b0;
      if (t == abort_t) begin
        #2 rst_n = 1'b0;
        #1 check_zero("abort");
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("no_done_after_abort", done, 0);
        end
        return;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    if (!seen) sb_q.delete();
  endtask

  initial begin
    logic [NV-1:0] rt;
    logic [NV-1:0] at;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    ref_tt   = '0;
    alt_tt   = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Consensus theorem: (x+y)(x'+z)(y+z) == (x+y)(x'+z)
    for (int v = 0; v < NV; v++) begin
      logic x, y, z;
      x = v[0]; y = v[1]; z = v[2];
      rt[v] = (x | y) & (~x | z) & (y | z);
      at[v] = (x | y) & (~x | z);
    end
    run_sweep(rt, at, -1, -1);
    @(negedge clk);
    chk("hold_vec_idle", vec_out, NV - 1);
    chk("hold_pass_idle", pass, 1);

    at = rt;
    at[5] = ~rt[5];
    run_sweep(rt, at, -1, -1);
    run_sweep(rt, ~rt, -1, -1);
    run_sweep(rt, ~rt, 4, -1);
    run_sweep(rt, at, -1, 8);
    run_sweep(rt, at, -1, -1);

    for (int k = 0; k < 20; k++) begin
      rt = NV'($urandom);
      case ($urandom_range(0, 2))
        0: at = rt;
        1: begin
          at = rt;
          at[$urandom_range(0, NV - 1)] ^= 1'b1;
        end
        default: at = NV'($urandom);
      endcase
      run_sweep(rt, at, -1, -1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
